mem_stage_multiport: RTL

//  Parametrised load/store execute stage for the OoO core: NUM_PORTS memory ops issued per cycle from the MIQ.

---
 rtl/core_pkg.sv | 59 +++++
 rtl/mem_stage_multiport_load_align.sv | 26 ++
 rtl/undo_checkpoint_module.sv | 30 +++
 rtl/mem_stage_multiport.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types for the load/store execute stage: MIQ issue lane, writeback port and stage register.
// Also holds the access-size helpers used by both issue and store logic.
package core_pkg;

   localparam int AL_SIZE = 32;
   localparam int AL_W    = $clog2(AL_SIZE);

   typedef enum logic [1:0] {
      MEM_B = 2'd0,
      MEM_H = 2'd1,
      MEM_W = 2'd2
   } mem_size_t;

   typedef enum logic {
      READ  = 1'b0,
      WRITE = 1'b1
   } mem_access_t;

   typedef struct packed {
      logic              valid;
      logic [AL_W-1:0]   al_addr;
      logic [31:0]       imm;
      logic [4:0]        rd;
      mem_access_t       mem_access_type;
      mem_size_t         mem_size;
      logic              mem_unsigned;
   } miq_ifc_t;

   typedef struct packed {
      logic              valid;
      logic [31:0]       data;
      logic [4:0]        rd;
      logic              uses_rd;
      logic [AL_W-1:0]   al_idx;
   } wb_ifc_t;

   typedef struct packed {
      logic              valid;
      logic [31:0]       data;
      logic [4:0]        rd;
      logic              uses_rd;
      logic [AL_W-1:0]   al_idx;
      logic              misalign;
   } wb_entry_t;

   function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] offset);
      return ((size == MEM_H) && offset[0]) || ((size == MEM_W) && (offset != 2'b00));
   endfunction

   // Only meaningful for aligned accesses, so the shifted mask never leaves the word.
   function automatic logic [3:0] byte_enable(input mem_size_t size, input logic [1:0] offset);
      case (size)
         MEM_B:   return 4'b0001 << offset;
         MEM_H:   return 4'b0011 << offset;
         default: return 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_multiport_load_align.sv
// Picks the addressed byte/half/word out of a merged 32-bit memory word and extends it to 32 bits.
module mem_load_align
   import core_pkg::*;
(
   input  logic [1:0]   offset,
   input  mem_size_t    size,
   input  logic         is_unsigned,
   input  logic [31:0]  word,
   output logic [31:0]  result
);

   logic [31:0] shifted;

   assign shifted = word >> {offset, 3'b000};

   // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
   always_comb begin
      result = word;
      case (size)
         MEM_B:   result = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
         MEM_H:   result = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
         default: result = word;
      endcase
   end

endmodule

// File: rtl/undo_checkpoint_module.sv
// Flags entries whose active-list index falls in the range discarded by a checkpoint recall.
// Ages are measured from the AL back so the range test is immune to index wrap-around.
module undo_checkpoint_module
   import core_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                        if_recall,
   input  logic [AL_W-1:0]             new_front,
   input  logic [AL_W-1:0]             old_front,
   input  logic [AL_W-1:0]             back,
   input  logic [DEPTH-1:0][AL_W-1:0]  al_addr,
   output logic [DEPTH-1:0]            flush
);

   logic [AL_W-1:0] lo_age;
   logic [AL_W-1:0] hi_age;

   assign lo_age = new_front - back;
   assign hi_age = old_front - back;

   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_entry
         logic [AL_W-1:0] age;
         assign age      = al_addr[i] - back;
         assign flush[i] = if_recall && (age >= lo_age) && (age < hi_age);
      end
   endgenerate

endmodule

// File: rtl/mem_stage_multiport.sv
// Multi-lane load/store execute stage: byte-enable stores, in-bundle store-to-load forwarding,
// a LAT-deep result pipeline and recall-driven squash of issue lanes and every pipeline stage.
module mem_stage_multiport
   import core_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int MEM_WORDS = 1024,
   parameter int LAT       = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_recall,
   input  logic [AL_W-1:0]       new_front,
   input  logic [AL_W-1:0]       old_front,
   input  logic [AL_W-1:0]       back,
   input  miq_ifc_t              i_miq [NUM_PORTS],
   input  logic [31:0]           i_regs [2*NUM_PORTS],
   output wb_ifc_t               o_wb [NUM_PORTS],
   output logic [NUM_PORTS-1:0]  o_misalign
);

   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam int EA_W  = IDX_W + 2;

   logic [31:0]                       mem [MEM_WORDS];
   logic [NUM_PORTS-1:0][EA_W-1:0]    ea;
   logic [NUM_PORTS-1:0][IDX_W-1:0]   word_idx;
   logic [NUM_PORTS-1:0][3:0]         be;
   logic [NUM_PORTS-1:0][31:0]        wdata;
   logic [NUM_PORTS-1:0][31:0]        merged;
   logic [NUM_PORTS-1:0][31:0]        ld_res;
   logic [NUM_PORTS-1:0][AL_W-1:0]    issue_al;
   logic [NUM_PORTS-1:0]              misal;
   logic [NUM_PORTS-1:0]              store_ok;
   logic [NUM_PORTS-1:0]              issue_flush;
   wb_entry_t [NUM_PORTS-1:0]         issue_entry;
   wb_entry_t [NUM_PORTS-1:0]         stage_q [LAT];
   logic [LAT-1:0][NUM_PORTS-1:0]     stage_flush;

   // Only the address bits that select a word and a byte matter, so EA is computed at that width.
   generate
      for (genvar k = 0; k < NUM_PORTS; k++) begin : g_lane
         assign ea[k]       = i_regs[2*k][EA_W-1:0] + i_miq[k].imm[EA_W-1:0];
         assign word_idx[k] = ea[k][EA_W-1:2];
         assign misal[k]    = is_misaligned(i_miq[k].mem_size, ea[k][1:0]);
         assign be[k]       = byte_enable(i_miq[k].mem_size, ea[k][1:0]);
         assign wdata[k]    = i_regs[2*k+1] << {ea[k][1:0], 3'b000};
         assign issue_al[k] = i_miq[k].al_addr;
         assign store_ok[k] = i_miq[k].valid & ~issue_flush[k] & ~misal[k]
                              & (i_miq[k].mem_access_type == WRITE);

         mem_load_align u_align (
            .offset      (ea[k][1:0]),
            .size        (i_miq[k].mem_size),
            .is_unsigned (i_miq[k].mem_unsigned),
            .word        (merged[k]),
            .result      (ld_res[k])
         );
      end
   endgenerate

   undo_checkpoint_module #(.DEPTH(NUM_PORTS)) u_undo_issue (
      .if_recall (if_recall),
      .new_front (new_front),
      .old_front (old_front),
      .back      (back),
      .al_addr   (issue_al),
      .flush     (issue_flush)
   );

   // Walking older lanes oldest-first lets the youngest older store claim each byte last.
   always_comb begin
      for (int k = 0; k < NUM_PORTS; k++) begin
         merged[k] = mem[word_idx[k]];
         for (int j = 0; j < k; j++) begin
            for (int b = 0; b < 4; b++) begin
               if (store_ok[j] && (word_idx[j] == word_idx[k]) && be[j][b]) begin
                  merged[k][8*b +: 8] = wdata[j][8*b +: 8];
               end
            end
         end
      end
   end

   always_comb begin
      issue_entry = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         issue_entry[k].valid    = i_miq[k].valid & ~issue_flush[k];
         issue_entry[k].al_idx   = i_miq[k].al_addr;
         issue_entry[k].misalign = misal[k];
         if (!misal[k] && (i_miq[k].mem_access_type == READ)) begin
            issue_entry[k].uses_rd = 1'b1;
            issue_entry[k].rd      = i_miq[k].rd;
            issue_entry[k].data    = ld_res[k];
         end
      end
   end

   // NOTE: the data array is deliberately not reset; only the valid-carrying pipeline needs a known state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int k = 0; k < NUM_PORTS; k++) begin
            for (int b = 0; b < 4; b++) begin
               if (store_ok[k] && be[k][b]) begin
                  mem[word_idx[k]][8*b +: 8] <= wdata[k][8*b +: 8];
               end
            end
         end
      end
   end

   generate
      for (genvar s = 0; s < LAT; s++) begin : g_stage
         logic [NUM_PORTS-1:0][AL_W-1:0] stage_al;
         for (genvar k = 0; k < NUM_PORTS; k++) begin : g_al
            assign stage_al[k] = stage_q[s][k].al_idx;
         end

         undo_checkpoint_module #(.DEPTH(NUM_PORTS)) u_undo_stage (
            .if_recall (if_recall),
            .new_front (new_front),
            .old_front (old_front),
            .back      (back),
            .al_addr   (stage_al),
            .flush     (stage_flush[s])
         );
      end
   endgenerate

   // NOTE: state is updated with non-blocking assignments so every stage shifts from its pre-edge value.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < LAT; s++) begin
            stage_q[s] <= '0;
         end
      end else begin
         stage_q[0] <= issue_entry;
         for (int s = 1; s < LAT; s++) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
               stage_q[s][k]       <= stage_q[s-1][k];
               stage_q[s][k].valid <= stage_q[s-1][k].valid & ~stage_flush[s-1][k];
            end
         end
      end
   end

   // The output stage is squashed combinationally so a recall never lets a dead result retire.
   always_comb begin
      o_misalign = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         o_wb[k].valid   = stage_q[LAT-1][k].valid & ~stage_flush[LAT-1][k];
         o_wb[k].data    = stage_q[LAT-1][k].data;
         o_wb[k].rd      = stage_q[LAT-1][k].rd;
         o_wb[k].uses_rd = stage_q[LAT-1][k].uses_rd & o_wb[k].valid;
         o_wb[k].al_idx  = stage_q[LAT-1][k].al_idx;
         o_misalign[k]   = stage_q[LAT-1][k].misalign & o_wb[k].valid;
      end
   end

endmodule
